// File: rtl/qam_demap_pkg.sv
// Shared definitions for the two-channel QAM demapper arbiter: state encoding,
// demapper latency, starvation timeout and the round-robin owner choice.
package qam_demap_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StGrant  = 2'b01,
        StStream = 2'b10,
        StDrain  = 2'b11
    } arb_state_e;

    // Cycles from an input pop to the matching output push.
    localparam int unsigned LAT       = 2;
    // Consecutive starved STREAM cycles that abort a frame (optional feature).
    localparam int unsigned TIMEOUT   = 64;
    localparam int unsigned TIMEOUT_W = $clog2(TIMEOUT + 1);

    // Prefer the non-empty channel that was not served last; fall back to the
    // last-served channel only if it is the sole non-empty one.
    function automatic logic pick_owner(input logic [1:0] rdempty, input logic last_served);
        logic other;
        other = ~last_served;
        if (!rdempty[other]) begin
            return other;
        end else if (!rdempty[last_served]) begin
            return last_served;
        end
        return other;
    endfunction

endpackage

// File: rtl/qam_demap_latency_pipe.sv
// LAT-deep valid/tag shift register mirroring the demapper datapath latency.
// out_valid is the input valid delayed LAT cycles; empty is high when no beat
// is in flight.
module qam_demap_latency_pipe
    import qam_demap_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic in_tag,
    output logic out_valid,
    output logic out_tag,
    output logic empty
);

    logic [LAT-1:0] valid_q;
    logic [LAT-1:0] tag_q;

    // Shift valid and channel tag one stage per cycle; reset drops all beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= {valid_q[LAT-2:0], in_valid};
            tag_q   <= {tag_q[LAT-2:0], in_tag};
        end
    end

    assign out_valid = valid_q[LAT-1];
    assign out_tag   = valid_q[LAT-1] & tag_q[LAT-1];
    assign empty     = ~|valid_q;

endmodule

// File: rtl/qam_demap_arbiter.sv
// Two-channel frame arbiter for a shared QAM demapper datapath.
// Whole frames are granted round-robin; the owner is popped while the output
// FIFO has room, and writes follow reads LAT cycles later.
// Optional feature: define QAM_ARB_TIMEOUT_EN to abort a frame after TIMEOUT
// consecutive starved STREAM cycles (frame_abort pulses with frame_done).
module qam_demap_arbiter
    import qam_demap_pkg::*;
#(
    parameter int unsigned FLEN_W = 8
) (
    input  logic              dclk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        rdempty,
    input  logic              wfull,
    input  logic [FLEN_W-1:0] frame_len,
    output logic [1:0]        read_enable,
    output logic              write_enable,
    output logic              wr_chan,
    output logic [1:0]        frame_done,
    output logic              frame_abort,
    output logic              busy,
    output logic [1:0]        state
);

    arb_state_e        state_q;
    logic [FLEN_W-1:0] count_q;
    logic              owner_q;
    logic              last_served_q;
    logic [1:0]        frame_done_q;
    logic              rd;
    logic              pipe_empty;
    logic              drain_done;
    logic              stall_hit;

    // Pop strobe is combinational so a stall on empty/full costs no cycle.
    assign rd = ~reset & (state_q == StStream) & enable & ~rdempty[owner_q] & ~wfull;
    assign read_enable = {rd & owner_q, rd & ~owner_q};
    assign drain_done  = (state_q == StDrain) & pipe_empty;

    qam_demap_latency_pipe u_pipe (
        .clk       (dclk),
        .reset     (reset),
        .in_valid  (rd),
        .in_tag    (owner_q),
        .out_valid (write_enable),
        .out_tag   (wr_chan),
        .empty     (pipe_empty)
    );

`ifdef QAM_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] stall_q;
    logic                 abort_pend_q;
    logic                 frame_abort_q;

    // stall_q holds the number of starved STREAM cycles before this one.
    assign stall_hit = (state_q == StStream) & rdempty[owner_q]
                     & (stall_q == TIMEOUT_W'(TIMEOUT - 1));

    // Count consecutive starved cycles and remember an abort until DRAIN ends.
    always_ff @(posedge dclk) begin
        if (reset) begin
            stall_q       <= '0;
            abort_pend_q  <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            if (state_q != StStream || !rdempty[owner_q] || stall_hit) begin
                stall_q <= '0;
            end else begin
                stall_q <= stall_q + 1'b1;
            end
            if (stall_hit) begin
                abort_pend_q <= 1'b1;
            end else if (drain_done) begin
                abort_pend_q <= 1'b0;
            end
            frame_abort_q <= drain_done & abort_pend_q;
        end
    end

    assign frame_abort = frame_abort_q;
`else
    assign stall_hit   = 1'b0;
    assign frame_abort = 1'b0;
`endif

    // Frame FSM: grant, stream count_q symbols, drain the pipe, report done.
    always_ff @(posedge dclk) begin
        if (reset) begin
            state_q       <= StIdle;
            count_q       <= '0;
            owner_q       <= 1'b0;
            last_served_q <= 1'b1;
            frame_done_q  <= '0;
        end else begin
            frame_done_q <= '0;
            case (state_q)
                StIdle: begin
                    if (enable && rdempty != 2'b11) begin
                        state_q <= StGrant;
                    end
                end
                StGrant: begin
                    owner_q <= pick_owner(rdempty, last_served_q);
                    // frame_len of 0 wraps to 2^FLEN_W reads naturally.
                    count_q <= frame_len;
                    state_q <= StStream;
                end
                StStream: begin
                    if (rd) begin
                        count_q <= count_q - 1'b1;
                        if (count_q == FLEN_W'(1)) begin
                            state_q <= StDrain;
                        end
                    end else if (stall_hit) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (pipe_empty) begin
                        frame_done_q  <= owner_q ? 2'b10 : 2'b01;
                        last_served_q <= owner_q;
                        state_q       <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign frame_done = frame_done_q;
    assign busy       = (state_q != StIdle);
    assign state      = state_q;

endmodule

// File: tb/tb_qam_demap_arbiter.sv
// Self-checking bench for qam_demap_arbiter: a cycle-level behavioural model
// (integer frame counter, timestamped write queue) is compared against the DUT
// on every cycle, plus directed scenarios with hand-computed expectations and
// a randomized soak.
module tb_qam_demap_arbiter;

    localparam int FLEN_W  = 8;
    localparam int TIMEOUT = 64;

    logic              dclk = 1'b0;
    logic              reset;
    logic              enable;
    logic [1:0]        rdempty;
    logic              wfull;
    logic [FLEN_W-1:0] frame_len;
    logic [1:0]        read_enable;
    logic              write_enable;
    logic              wr_chan;
    logic [1:0]        frame_done;
    logic              frame_abort;
    logic              busy;
    logic [1:0]        state;

    qam_demap_arbiter #(.FLEN_W(FLEN_W)) dut (
        .dclk         (dclk),
        .reset        (reset),
        .enable       (enable),
        .rdempty      (rdempty),
        .wfull        (wfull),
        .frame_len    (frame_len),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .wr_chan      (wr_chan),
        .frame_done   (frame_done),
        .frame_abort  (frame_abort),
        .busy         (busy),
        .state        (state)
    );

    always #5 dclk = ~dclk;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int   t;
        logic ch;
    } wr_t;

    wr_t  wq[$];
    int   m_state = 0;
    int   m_rem = 0;
    logic m_owner = 1'b0;
    logic m_last = 1'b1;
    int   m_stall = 0;
    int   m_abort_pend = 0;
    int   m_done = 0;
    int   m_abort = 0;
    int   cyc = 0;
    bit   armed = 1'b0;

    int rd_cnt0, rd_cnt1, wr_cnt, overlap_cnt;
    int done_log[$];
    int abort_log[$];

    function automatic int log_at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    always @(negedge dclk) begin : model
        int   rd;
        int   exp_we;
        logic exp_wc;
        int   pipe_empty;
        int   nd;
        int   na;
        logic o;

        rd = (!reset && m_state == 2 && enable && !rdempty[m_owner] && !wfull) ? 1 : 0;
        exp_we = (wq.size() > 0 && wq[0].t == cyc) ? 1 : 0;
        exp_wc = exp_we ? wq[0].ch : 1'b0;
        pipe_empty = (wq.size() == 0) ? 1 : 0;

        if (armed) begin
            check("read_enable", int'(read_enable), rd << m_owner);
            check("write_enable", int'(write_enable), exp_we);
            if (exp_we != 0) check("wr_chan", int'(wr_chan), int'(exp_wc));
            check("frame_done", int'(frame_done), m_done);
            check("frame_abort", int'(frame_abort), m_abort);
            check("busy", int'(busy), (m_state != 0) ? 1 : 0);
            check("state", int'(state), m_state);
            if (read_enable[0]) rd_cnt0++;
            if (read_enable[1]) rd_cnt1++;
            if (read_enable == 2'b11) overlap_cnt++;
            if (write_enable) wr_cnt++;
            if (frame_done != 2'b00) done_log.push_back(int'(frame_done));
            if (frame_abort) abort_log.push_back(int'(frame_done));
        end

        if (exp_we != 0) void'(wq.pop_front());

        nd = 0;
        na = 0;
        if (reset) begin
            m_state = 0;
            m_rem = 0;
            m_owner = 1'b0;
            m_last = 1'b1;
            m_stall = 0;
            m_abort_pend = 0;
            wq.delete();
            armed = 1'b1;
        end else begin
            case (m_state)
                0: if (enable && rdempty != 2'b11) m_state = 1;
                1: begin
                    o = ~m_last;
                    if (!rdempty[o]) m_owner = o;
                    else if (!rdempty[m_last]) m_owner = m_last;
                    else m_owner = o;
                    m_rem = (frame_len == 0) ? (1 << FLEN_W) : int'(frame_len);
                    m_stall = 0;
                    m_state = 2;
                end
                2: begin
                    if (rd != 0) begin
                        wq.push_back('{cyc + 2, m_owner});
                        m_rem--;
                        if (m_rem == 0) m_state = 3;
                    end
`ifdef QAM_ARB_TIMEOUT_EN
                    if (rdempty[m_owner]) m_stall++;
                    else m_stall = 0;
                    if (m_stall == TIMEOUT) begin
                        m_state = 3;
                        m_abort_pend = 1;
                    end
`endif
                end
                default: begin
                    if (pipe_empty != 0) begin
                        nd = 1 << m_owner;
                        na = m_abort_pend;
                        m_abort_pend = 0;
                        m_last = m_owner;
                        m_state = 0;
                    end
                end
            endcase
        end
        m_done = nd;
        m_abort = na;
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge dclk);
        #1;
    endtask

    task automatic clear_stats();
        rd_cnt0 = 0;
        rd_cnt1 = 0;
        wr_cnt = 0;
        overlap_cnt = 0;
        done_log.delete();
        abort_log.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rdempty = 2'b11;
        step(1);
        reset = 1'b0;
        clear_stats();
    endtask

    initial begin
        int r;
        int w;
        reset = 1'b1;
        enable = 1'b0;
        rdempty = 2'b11;
        wfull = 1'b0;
        frame_len = 8'd4;
        step(3);
        reset = 1'b0;
        check("rst_read_enable", int'(read_enable), 0);
        check("rst_write_enable", int'(write_enable), 0);
        check("rst_wr_chan", int'(wr_chan), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_frame_abort", int'(frame_abort), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_state", int'(state), 0);

        // Single channel, 4-symbol frame.
        do_reset();
        frame_len = 8'd4;
        rdempty = 2'b10;
        enable = 1'b1;
        for (int i = 0; i < 40 && done_log.size() == 0; i++) begin
            step(1);
            if (rd_cnt0 >= 4) rdempty = 2'b11;
        end
        check("t1_done_seen", done_log.size(), 1);
        check("t1_reads_ch0", rd_cnt0, 4);
        check("t1_reads_ch1", rd_cnt1, 0);
        check("t1_writes", wr_cnt, 4);
        check("t1_done_ch0", log_at(done_log, 0), 1);
        step(2);
        check("t1_idle", int'(state), 0);

        // Both channels busy: frames alternate starting with channel 0.
        do_reset();
        frame_len = 8'd3;
        rdempty = 2'b00;
        for (int i = 0; i < 200 && done_log.size() < 4; i++) step(1);
        rdempty = 2'b11;
        check("t2_frames", (done_log.size() >= 4) ? 1 : 0, 1);
        check("t2_order0", log_at(done_log, 0), 1);
        check("t2_order1", log_at(done_log, 1), 2);
        check("t2_order2", log_at(done_log, 2), 1);
        check("t2_order3", log_at(done_log, 3), 2);
        check("t2_overlap", overlap_cnt, 0);

        // Output almost-full for 5 cycles mid-frame.
        do_reset();
        frame_len = 8'd10;
        rdempty = 2'b10;
        for (int i = 0; i < 40 && rd_cnt0 < 4; i++) step(1);
        wfull = 1'b1;
        r = rd_cnt0;
        w = wr_cnt;
        step(5);
        check("t3_reads_in_window", rd_cnt0 - r, 0);
        check("t3_writes_in_window", wr_cnt - w, 2);
        wfull = 1'b0;
        for (int i = 0; i < 60 && done_log.size() == 0; i++) begin
            step(1);
            if (rd_cnt0 >= 10) rdempty = 2'b11;
        end
        check("t3_total_reads", rd_cnt0, 10);
        check("t3_done", log_at(done_log, 0), 1);

        // frame_len 0 means 256 symbols.
        do_reset();
        frame_len = 8'd0;
        rdempty = 2'b10;
        for (int i = 0; i < 400 && done_log.size() == 0; i++) begin
            step(1);
            if (rd_cnt0 >= 256) rdempty = 2'b11;
        end
        check("t4_reads_256", rd_cnt0, 256);
        check("t4_done", log_at(done_log, 0), 1);

        // Reset with reads in flight discards the pending writes.
        do_reset();
        frame_len = 8'd20;
        rdempty = 2'b10;
        for (int i = 0; i < 40 && rd_cnt0 < 5; i++) step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("t5_we_after_reset", int'(write_enable), 0);
        check("t5_state_after_reset", int'(state), 0);
        w = wr_cnt;
        step(3);
        check("t5_no_late_writes", wr_cnt - w, 0);

`ifdef QAM_ARB_TIMEOUT_EN
        // Starved owner times out; the next grant goes to the other channel.
        do_reset();
        frame_len = 8'd10;
        rdempty = 2'b10;
        for (int i = 0; i < 40 && rd_cnt0 < 3; i++) step(1);
        rdempty = 2'b01;
        for (int i = 0; i < 120 && done_log.size() == 0; i++) step(1);
        check("t6_abort_count", abort_log.size(), 1);
        check("t6_abort_with_done0", log_at(abort_log, 0), 1);
        check("t6_done0", log_at(done_log, 0), 1);
        for (int i = 0; i < 60 && done_log.size() < 2; i++) step(1);
        check("t6_next_grant_ch1", log_at(done_log, 1), 2);
        check("t6_ch1_reads", rd_cnt1, 10);
`endif

        // Randomized soak against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            enable    = ($urandom_range(0, 9) != 0);
            rdempty   = {($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3)};
            wfull     = ($urandom_range(0, 9) < 2);
            frame_len = ($urandom_range(0, 19) == 0) ? 8'd0 : 8'($urandom_range(1, 8));
            reset     = ($urandom_range(0, 499) == 0);
            step(1);
        end
        reset = 1'b0;
        check("rand_frames_completed", (done_log.size() > 0) ? 1 : 0, 1);
        check("rand_overlap", overlap_cnt, 0);
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/qam_demap_arbiter.md
QAM_DEMAP_ARBITER -- requirements
Module: qam_demap_arbiter

Interface
REQ-001 Parameter: FLEN_W, default 8, width of frame_len and of the internal symbol counter.
REQ-002 Port: dclk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: enable  input  1  global run enable; low pauses symbol issue.
REQ-005 Port: rdempty  input  2  per-channel input symbol FIFO empty flags; bit0 = channel 0.
REQ-006 Port: wfull  input  1  output bit-FIFO almost-full; asserts with at least LAT free entries.
REQ-007 Port: frame_len  input  FLEN_W  symbols per frame; sampled in GRANT; 0 means 2^FLEN_W.
REQ-008 Port: read_enable  output  2  one-hot pop strobe to the owning channel's input FIFO.
REQ-009 Port: write_enable  output  1  push strobe to the output FIFO, aligned with demapper output.
REQ-010 Port: wr_chan  output  1  channel tag of the current write_enable beat.
REQ-011 Port: frame_done  output  2  one-cycle pulse per channel on frame completion.
REQ-012 Port: frame_abort  output  1  one-cycle pulse when a frame ends by starvation timeout.
REQ-013 Port: busy  output  1  high in every state other than IDLE.
REQ-014 Port: state  output  2  current FSM state encoding.

Function
REQ-015 The block SHALL share one demapper datapath between two channels, granting whole frames round-robin.
REQ-016 States SHALL be IDLE=00, GRANT=01, STREAM=10, DRAIN=11.
REQ-017 IDLE->GRANT when enable=1 and any rdempty bit=0; otherwise stay in IDLE.
REQ-018 In GRANT (one cycle), owner SHALL be the non-empty channel other than last_served; the other channel only if it alone is non-empty; load count from frame_len; then ->STREAM.
REQ-019 In STREAM, read_enable[owner]=enable & ~rdempty[owner] & ~wfull; at most one read per cycle; non-owner bit always 0.
REQ-020 Each read SHALL decrement count; the read taking count to 0 moves the FSM to DRAIN next cycle.
REQ-021 write_enable SHALL equal read_enable delayed exactly LAT=2 cycles, with wr_chan carrying the owner tag; wfull SHALL NOT gate writes.
REQ-022 DRAIN SHALL wait until the latency pipe is empty, then pulse frame_done[owner] for one cycle, set last_served=owner, and go to IDLE.
REQ-023 enable low in STREAM SHALL pause reads without leaving the frame; in-flight writes still complete.
REQ-024 rdempty[owner] high in STREAM SHALL stall reads; the frame is not abandoned unless REQ-029 applies.
REQ-025 Simultaneous non-empty channels after reset SHALL grant channel 0 first (last_served resets to 1).

Reset
REQ-026 On reset: state=IDLE, count=0, last_served=1, and the latency pipe cleared.
REQ-027 On reset, read_enable, write_enable, wr_chan, frame_done, frame_abort and busy SHALL all be 0.
REQ-028 Reset mid-frame SHALL discard in-flight writes (write_enable 0 from the next cycle) with no frame_done pulse.

Configuration
REQ-029 With QAM_ARB_TIMEOUT_EN defined, 64 consecutive STREAM cycles with rdempty[owner]=1 SHALL force DRAIN, pulse frame_abort with frame_done[owner], and set last_served=owner.
REQ-030 Without QAM_ARB_TIMEOUT_EN, STREAM SHALL wait indefinitely and frame_abort SHALL be tied to 0.

Structure
REQ-031 Package qam_demap_pkg SHALL hold the state encoding, LAT=2 and TIMEOUT=64.
REQ-032 Sub-module qam_demap_latency_pipe SHALL implement the LAT-deep valid/tag shift register and an empty flag.

Verification
REQ-033 frame_len=4, ch0 non-empty, ch1 empty -> 4 read_enable[0] pulses, 4 writes with wr_chan=0 each 2 cycles later, then frame_done[0], then IDLE.
REQ-034 Both non-empty, frame_len=3 -> frames alternate 0,1,0,1; no read_enable overlap between channels.
REQ-035 wfull=1 for 5 cycles mid-frame -> no reads in that window; already-issued writes still occur; count is preserved.
REQ-036 frame_len=0, FLEN_W=8 -> exactly 256 reads before DRAIN.
REQ-037 Reset asserted in STREAM with 2 reads in flight -> zero write_enable after the reset edge; state=00.
REQ-038 With QAM_ARB_TIMEOUT_EN, rdempty[owner]=1 for 64 cycles mid-frame -> frame_abort and frame_done[owner] pulse together; the next grant goes to the other channel.
